// File: rtl/bcd_seg_scanner_if.sv
// Digit/display bundle for bcd_seg_scanner: the BCD load side in, the
// multiplexed segment/anode drive and status out.
interface bcd_seg_scanner_if;
    logic       load;
    logic [3:0] bcd_0;
    logic [3:0] bcd_1;
    logic [3:0] bcd_2;
    logic [3:0] bcd_3;
    logic [6:0] seg_n;
    logic [3:0] an_n;
    logic       pending;
    logic       frame_done;

    modport master (
        output load, bcd_0, bcd_1, bcd_2, bcd_3,
        input  seg_n, an_n, pending, frame_done
    );

    modport slave (
        input  load, bcd_0, bcd_1, bcd_2, bcd_3,
        output seg_n, an_n, pending, frame_done
    );
endinterface

// File: rtl/bcd_seg_scanner.sv
// Four-digit multiplexed seven-segment scanner with a frame-synchronous
// shadow register. Optional macro LEADING_ZERO_BLANK_EN blanks leading zeros.
module bcd_seg_scanner #(
    parameter int REFRESH_DIV = 50000
) (
    input  logic           clk,
    input  logic           rst_n,
    bcd_seg_scanner_if.slave bus_io
);

    localparam int             CW       = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0]  CNT_LAST = CW'(REFRESH_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    idx_q, idx_d;
    logic [15:0]   shadow_q, shadow_d;
    logic [15:0]   disp_q, disp_d;
    logic          pending_q, pending_d;
    logic [6:0]    seg_q, seg_d;
    logic [3:0]    an_q, an_d;

    logic [15:0]   bcd_in;
    logic          wrap;
    logic          boundary;

    assign bcd_in   = {bus_io.bcd_3, bus_io.bcd_2, bus_io.bcd_1, bus_io.bcd_0};
    assign wrap     = (cnt_q == CNT_LAST);
    assign boundary = wrap && (idx_q == 2'd3);

    function automatic logic [6:0] decode(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = 7'h3F;
        endcase
        return s;
    endfunction

    // A digit is a leading zero when it and every digit to its left are 0;
    // digit 0 always shows so a zero value still reads "0".
    function automatic logic is_leading_zero(input logic [15:0] d, input logic [1:0] k);
        logic z;
        case (k)
            2'd3:    z = (d[15:12] == 4'd0);
            2'd2:    z = (d[15:8]  == 8'd0);
            2'd1:    z = (d[15:4]  == 12'd0);
            default: z = 1'b0;
        endcase
        return z;
    endfunction

    function automatic logic [6:0] digit_seg(input logic [15:0] d, input logic [1:0] k);
        logic [6:0] s;
        s = decode(d[{k, 2'b00} +: 4]);
`ifdef LEADING_ZERO_BLANK_EN
        if (is_leading_zero(d, k)) begin
            s = 7'h7F;
        end
`else
        if (1'b0 && is_leading_zero(d, k)) begin
            s = 7'h7F;
        end
`endif
        return s;
    endfunction

    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        cnt_d     = cnt_q + 1'b1;
        idx_d     = idx_q;
        shadow_d  = shadow_q;
        disp_d    = disp_q;
        pending_d = pending_q;

        if (wrap) begin
            cnt_d = '0;
            idx_d = idx_q + 2'd1;
        end

        if (bus_io.load) begin
            shadow_d  = bcd_in;
            pending_d = 1'b1;
        end

        // A load landing on the boundary bypasses the shadow so it is not lost for a frame.
        if (boundary) begin
            pending_d = 1'b0;
            if (bus_io.load) begin
                disp_d = bcd_in;
            end else if (pending_q) begin
                disp_d = shadow_q;
            end
        end

        an_d  = ~(4'b0001 << idx_d);
        seg_d = digit_seg(disp_d, idx_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: sequential state uses non-blocking assignments so all flops update together.
            cnt_q     <= '0;
            idx_q     <= 2'd0;
            shadow_q  <= 16'h0000;
            disp_q    <= 16'h0000;
            pending_q <= 1'b0;
            seg_q     <= 7'h7F;
            an_q      <= 4'hF;
        end else begin
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            shadow_q  <= shadow_d;
            disp_q    <= disp_d;
            pending_q <= pending_d;
            seg_q     <= seg_d;
            an_q      <= an_d;
        end
    end

    assign bus_io.seg_n      = seg_q;
    assign bus_io.an_n       = an_q;
    assign bus_io.pending    = pending_q;
    assign bus_io.frame_done = boundary;

endmodule

// File: tb/tb_bcd_seg_scanner.sv
// Randomised self-checking bench for bcd_seg_scanner against a time-based
// behavioural model, plus a REFRESH_DIV=1 instance checked for scan rate.
module tb_bcd_seg_scanner;

    localparam int D     = 4;
    localparam int FRAME = 4 * D;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bcd_seg_scanner_if bus ();
    bcd_seg_scanner_if bus1 ();

    bcd_seg_scanner #(.REFRESH_DIV(D)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus_io (bus.slave)
    );

    bcd_seg_scanner #(.REFRESH_DIV(1)) dut1 (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus_io (bus1.slave)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: position in the scan derives from the edge count n.
    logic [6:0] lut [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};
    int n = 0;
    bit started = 1'b0;
    int m_disp [4];
    int m_shadow [4];
    bit m_pend = 1'b0;

    function automatic logic [6:0] exp_seg(input int k);
`ifdef LEADING_ZERO_BLANK_EN
        if (k > 0) begin
            bit all0 = 1'b1;
            for (int j = k; j < 4; j++) if (m_disp[j] != 0) all0 = 1'b0;
            if (all0) return 7'h7F;
        end
`endif
        return lut[m_disp[k]];
    endfunction

    initial begin : model
        int  in_d [4];
        bit  bnd;
        for (int i = 0; i < 4; i++) begin m_disp[i] = 0; m_shadow[i] = 0; end
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                n = 0; started = 1'b0; m_pend = 1'b0;
                for (int i = 0; i < 4; i++) begin m_disp[i] = 0; m_shadow[i] = 0; end
            end else begin
                in_d[0] = int'(bus.bcd_0); in_d[1] = int'(bus.bcd_1);
                in_d[2] = int'(bus.bcd_2); in_d[3] = int'(bus.bcd_3);
                bnd = ((n % FRAME) == FRAME - 1);
                if (bnd) begin
                    if (bus.load)    for (int i = 0; i < 4; i++) m_disp[i] = in_d[i];
                    else if (m_pend) for (int i = 0; i < 4; i++) m_disp[i] = m_shadow[i];
                    m_pend = 1'b0;
                end else if (bus.load) begin
                    m_pend = 1'b1;
                end
                if (bus.load) for (int i = 0; i < 4; i++) m_shadow[i] = in_d[i];
                n++;
                started = 1'b1;
            end
        end
    end

    // Compare process: every falling edge, both instances against the model.
    always @(negedge clk) begin : compare
        int         idx;
        logic [3:0] onehot;
        idx    = (n / D) % 4;
        onehot = 4'b0001 << idx;
        check("seg_n",      {25'd0, bus.seg_n},   {25'd0, started ? exp_seg(idx) : 7'h7F});
        check("an_n",       {28'd0, bus.an_n},    {28'd0, started ? ~onehot : 4'hF});
        check("pending",    {31'd0, bus.pending}, {31'd0, m_pend});
        check("frame_done", {31'd0, bus.frame_done},
              {31'd0, (rst_n && ((n % FRAME) == FRAME - 1))});
        onehot = 4'b0001 << (n % 4);
        check("div1_an_n",       {28'd0, bus1.an_n},  {28'd0, started ? ~onehot : 4'hF});
        check("div1_seg_n",      {25'd0, bus1.seg_n}, {25'd0, started ? 7'h40 : 7'h7F});
        check("div1_frame_done", {31'd0, bus1.frame_done}, {31'd0, (rst_n && ((n % 4) == 3))});
    end

    bit watch_79 = 1'b0;
    bit saw_79   = 1'b0;
    always @(negedge clk) if (watch_79 && bus.seg_n == 7'h79) saw_79 = 1'b1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_digits(input int d3, input int d2, input int d1, input int d0);
        bus.bcd_3 = 4'(d3); bus.bcd_2 = 4'(d2); bus.bcd_1 = 4'(d1); bus.bcd_0 = 4'(d0);
    endtask

    task automatic load_once(input int d3, input int d2, input int d1, input int d0);
        set_digits(d3, d2, d1, d0);
        bus.load = 1'b1;
        tick();
        bus.load = 1'b0;
    endtask

    // Leaves the bench positioned inside the boundary cycle.
    task automatic wait_boundary();
        int k;
        k = 0;
        while (!bus.frame_done && k <= FRAME) begin
            tick();
            k++;
        end
        if (!bus.frame_done) check("boundary_timeout", 32'd0, 32'd1);
    endtask

    initial begin : stimulus
        bus.load = 1'b0;  set_digits(0, 0, 0, 0);
        bus1.load = 1'b0; bus1.bcd_0 = 4'd0; bus1.bcd_1 = 4'd0; bus1.bcd_2 = 4'd0; bus1.bcd_3 = 4'd0;

        repeat (3) @(posedge clk);
        #1;
        check("reset_seg",  {25'd0, bus.seg_n},   32'h7F);
        check("reset_an",   {28'd0, bus.an_n},    32'hF);
        check("reset_pend", {31'd0, bus.pending}, 32'd0);
        rst_n = 1'b1;
        tick();
        check("first_an",  {28'd0, bus.an_n},  32'hE);
        check("first_seg", {25'd0, bus.seg_n}, 32'h40);

        // Load mid-frame in cycle 5.
        repeat (3) tick();
        load_once(1, 2, 3, 4);
        check("midload_pend", {31'd0, bus.pending}, 32'd1);
        repeat (10) tick();
        check("c16_frame_done", {31'd0, bus.frame_done}, 32'd1);
        check("c16_pend",       {31'd0, bus.pending},    32'd1);
        tick();
        check("commit_pend", {31'd0, bus.pending}, 32'd0);
        check("commit_an",   {28'd0, bus.an_n},    32'hE);
        check("commit_d0",   {25'd0, bus.seg_n},   32'h19);
        repeat (D) tick();
        check("commit_d1",   {25'd0, bus.seg_n},   32'h30);

        // Boundary collision.
        wait_boundary();
        load_once(9, 8, 7, 6);
        check("collide_seg",  {25'd0, bus.seg_n},   32'h02);
        check("collide_pend", {31'd0, bus.pending}, 32'd0);

        // Back-to-back loads within one frame: last wins.
        saw_79 = 1'b0; watch_79 = 1'b1;
        load_once(1, 1, 1, 1);
        tick();
        load_once(5, 5, 5, 5);
        wait_boundary();
        tick();
        check("b2b_seg", {25'd0, bus.seg_n}, 32'h12);
        repeat (FRAME) tick();
        watch_79 = 1'b0;
        check("b2b_never_1", {31'd0, saw_79}, 32'd0);

        // Invalid code on digit 0.
        load_once(0, 0, 0, 12);
        wait_boundary();
        tick();
        check("dash_seg", {25'd0, bus.seg_n}, 32'h3F);

        // Leading zeros.
        load_once(0, 0, 4, 2);
        wait_boundary();
        tick();
        check("lz_d0", {25'd0, bus.seg_n}, 32'h24);
        repeat (D) tick();
        check("lz_d1", {25'd0, bus.seg_n}, 32'h19);
        repeat (D) tick();
`ifdef LEADING_ZERO_BLANK_EN
        check("lz_d2", {25'd0, bus.seg_n}, 32'h7F);
        repeat (D) tick();
        check("lz_d3", {25'd0, bus.seg_n}, 32'h7F);
`else
        check("lz_d2", {25'd0, bus.seg_n}, 32'h40);
        repeat (D) tick();
        check("lz_d3", {25'd0, bus.seg_n}, 32'h40);
`endif

        // Randomised loads, some forced onto the boundary, some back-to-back.
        for (int it = 0; it < 200; it++) begin
            case ($urandom_range(3))
                0:       wait_boundary();
                default: repeat ($urandom_range(2 * FRAME)) tick();
            endcase
            load_once($urandom_range(15), $urandom_range(15), $urandom_range(15), $urandom_range(15));
            if ($urandom_range(3) == 0)
                load_once($urandom_range(9), $urandom_range(9), $urandom_range(9), $urandom_range(9));
        end

        // Reset mid-frame with data pending.
        wait_boundary();
        tick();
        load_once(7, 7, 7, 7);
        check("prerst_pend", {31'd0, bus.pending}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_seg",  {25'd0, bus.seg_n},   32'h7F);
        check("rst_an",   {28'd0, bus.an_n},    32'hF);
        check("rst_pend", {31'd0, bus.pending}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        check("post_an",   {28'd0, bus.an_n},    32'hE);
        check("post_seg",  {25'd0, bus.seg_n},   32'h40);
        check("post_pend", {31'd0, bus.pending}, 32'd0);
        repeat (2 * FRAME) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bcd_seg_scanner.md
# bcd_seg_scanner

Time-multiplexed 4-digit seven-segment driver that sits directly downstream of the binary-to-BCD converter and digit mux. It consumes four 4-bit BCD digits and latches them on a load strobe. Each digit is decoded to active-low segments and scanned across four active-low anodes at a programmable refresh rate. New values are committed only at a frame boundary, so the display never shows a mix of old and new digits.

## Interface
- REFRESH_DIV, 50000: clock cycles each digit stays lit; must be ≥ 1; prescaler width is $clog2(REFRESH_DIV), minimum 1.
- clk  in  1  system clock, all state rises on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- load  in  1  one-cycle strobe; captures bcd_0..bcd_3 into the shadow register.
- bcd_0  in  4  ones digit (rightmost).
- bcd_1  in  4  tens digit.
- bcd_2  in  4  hundreds digit.
- bcd_3  in  4  thousands digit (leftmost).
- seg_n  out  7  active-low segments {g,f,e,d,c,b,a}.
- an_n  out  4  active-low anode enables; bit k is digit k.
- pending  out  1  shadow holds data not yet committed.
- frame_done  out  1  one-cycle pulse at the end of each full 4-digit scan.

## Operation
- State: prescaler cnt, digit index idx (0..3), shadow[15:0], disp[15:0], pending.
- cnt counts 0..REFRESH_DIV-1 and wraps. On wrap, idx increments modulo 4 (order 0→1→2→3→0).
- Frame boundary: the cycle where cnt wraps while idx==3. On that edge:
  - frame_done is 1 for exactly that cycle.
  - If pending is set, disp takes shadow and pending clears.
- load: shadow takes {bcd_3,bcd_2,bcd_1,bcd_0} and pending sets. If several loads arrive before a boundary, the last one wins.
- load on the boundary cycle: the incoming digits are written into disp directly, shadow is also updated, and pending ends at 0.
- Decode (seg_n, hex): 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10. Codes 10–15 show a dash, 3F (segment g only). Blank is 7F.
- an_n = ~(1<<idx). Exactly one anode is low at all times outside reset.

## Timing
- Reset values: seg_n=7F, an_n=F, pending=0, frame_done=0. Internally cnt=0, idx=0, shadow=0, disp=0.
- seg_n and an_n are registered. They are computed from the next-state idx and disp, so they change on the same edge as idx or disp.
- After rst_n deasserts, the first posedge gives an_n=E and seg_n=40 (digit 0 shows "0").
- Each digit is lit for exactly REFRESH_DIV cycles. One frame is 4·REFRESH_DIV cycles.
- Worst-case load-to-display latency is 4·REFRESH_DIV cycles. A load on the boundary cycle appears on the next edge.
- REFRESH_DIV=1: idx advances every cycle, and frame_done pulses every 4th cycle.
- rst_n asserted mid-frame: all state clears immediately (asynchronous), any pending data is lost, and outputs blank until the next posedge after release.

## Configuration
- LEADING_ZERO_BLANK_EN
  - Defined: digit k (k=3,2,1) is blanked (seg_n=7F, anode still driven) when its value is 0 and every higher digit in disp is 0. Digit 0 is never blanked. A dash code (10–15) counts as non-zero.
  - Undefined: all digits are always decoded, leading zeros included.

## Test plan
- Reset then scan, REFRESH_DIV=4: after release, an_n sequence is E,D,B,7, each for 4 cycles. seg_n=40 throughout. frame_done pulses at cycles 16, 32, ...
- Load mid-frame: load bcd={1,2,3,4} (bcd_3..bcd_0) at cycle 5.
  - pending=1 until cycle 16, then clears.
  - The next frame shows seg_n 19,30,24,79 for digits 0..3.
  - Between cycle 5 and 16 the display still shows 40 on every digit.
- Boundary collision: load {9,8,7,6} exactly on the frame_done cycle. The next edge shows digit 0=02 and pending stays 0.
- Back-to-back loads: {1,1,1,1} then {5,5,5,5} within one frame. Only 12 is ever displayed.
- Invalid code: load bcd_0=4'hC. Digit 0 shows 3F.
- Blanking, macro defined: load {0,0,4,2}. Digits 3 and 2 show 7F, digit 1 shows 19, digit 0 shows 24. With the macro undefined, digits 3 and 2 show 40.
- Reset mid-frame with pending=1: outputs return to 7F/F at once. After release, digits show 0 and pending=0.
